// File: rtl/mux2x1_rr_arbiter_pkg.sv
// Shared state encodings, grant constants and small helpers for the mux2x1 round-robin arbiter.
package mux2x1_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arbState_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  function automatic logic [1:0] grantOf(input logic owner);
    return owner ? GNT_1 : GNT_0;
  endfunction

  function automatic arbState_t stateOf(input logic owner);
    return owner ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/mux2x1.sv
// Two-input datapath multiplexer whose select line is driven by mux2x1_rr_arbiter.
module mux2x1 #(
  parameter int unsigned W = 1
) (
  input  logic [1:0][W-1:0] din,
  input  logic              sel,
  output logic [W-1:0]      dout
);

  assign dout = din[sel];

endmodule

// File: rtl/mux2x1_arb_holdcnt.sv
// Saturating hold counter used for grant preemption; instantiated only when MUX_ARB_TIMEOUT_EN is defined.
module mux2x1_arb_holdcnt #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_atMax
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] r_count;

  // Clear wins over increment so a grant change always restarts the hold window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX_CNT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_atMax = (r_count == MAX_CNT);

endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin arbiter sharing one mux2x1 between two requesters; all outputs registered.
// Define MUX_ARB_TIMEOUT_EN to build the hold counter that preempts an owner after MAX_HOLD cycles.
module mux2x1_rr_arbiter
  import mux2x1_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       sel,
  output logic       busy
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || (CNT_W < 1) || ((MAX_HOLD >> CNT_W) != 0))
  begin : g_badParams
    $error("mux2x1_rr_arbiter: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  arbState_t  r_state;
  logic [1:0] r_grant;
  logic       r_sel;
  logic       r_busy;
  logic       r_lastOwner;

  logic       w_other;
  logic       w_take;
  logic       w_goIdle;
  logic       w_newOwner;
  logic       w_preempt;

  assign w_other = ~r_sel;

  // In an OWN state r_sel is the owner index, so release and hand-off are judged against it.
  always_comb begin
    w_take     = 1'b0;
    w_goIdle   = 1'b0;
    w_newOwner = r_sel;
    case (r_state)
      ARB_IDLE: begin
        if (req != 2'b00) begin
          w_take     = 1'b1;
          w_newOwner = (req == 2'b11) ? ~r_lastOwner : req[1];
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!req[r_sel] || w_preempt) begin
          if (req[w_other]) begin
            w_take     = 1'b1;
            w_newOwner = w_other;
          end else begin
            w_goIdle = 1'b1;
          end
        end
      end
      default: w_goIdle = 1'b1;
    endcase
  end

`ifdef MUX_ARB_TIMEOUT_EN
  logic w_atMax;
  logic w_holdClr;
  logic w_holdInc;

  assign w_holdClr = w_take | w_goIdle | (r_state == ARB_IDLE);
  assign w_holdInc = (r_state != ARB_IDLE);
  assign w_preempt = w_atMax & req[w_other];

  mux2x1_arb_holdcnt #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_holdCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_holdClr),
    .i_inc   (w_holdInc),
    .o_atMax (w_atMax)
  );
`else
  assign w_preempt = 1'b0;
`endif

  // sel is left untouched on the way to IDLE so the mux output stays on the last owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_grant     <= GNT_NONE;
      r_sel       <= 1'b0;
      r_busy      <= 1'b0;
      r_lastOwner <= 1'b1;
    end else if (w_take) begin
      r_state     <= stateOf(w_newOwner);
      r_grant     <= grantOf(w_newOwner);
      r_sel       <= w_newOwner;
      r_busy      <= 1'b1;
      r_lastOwner <= w_newOwner;
    end else if (w_goIdle) begin
      r_state <= ARB_IDLE;
      r_grant <= GNT_NONE;
      r_busy  <= 1'b0;
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Directed self-checking bench for mux2x1_rr_arbiter driving a real mux2x1 (din0=1, din1=0).
module tb_mux2x1_rr_arbiter;
  import mux2x1_rr_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] grant;
  logic       sel;
  logic       busy;
  logic       dout;

  int checkCount = 0;
  int errorCount = 0;

  mux2x1_rr_arbiter #(
    .MAX_HOLD (4),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .busy  (busy)
  );

  mux2x1 #(
    .W (1)
  ) u_mux (
    .din  (2'b01),
    .sel  (sel),
    .dout (dout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // din0=1 and din1=0, so the mux output is the inverse of the expected select.
  task automatic checkState(input string tag, input logic [1:0] expGrant,
                            input logic expSel, input logic expBusy);
    checkOutput({tag, ".grant"}, 32'(grant), 32'(expGrant));
    checkOutput({tag, ".sel"},   32'(sel),   32'(expSel));
    checkOutput({tag, ".busy"},  32'(busy),  32'(expBusy));
    checkOutput({tag, ".dout"},  32'(dout),  32'(expSel ? 1'b0 : 1'b1));
  endtask

  task automatic applyStimulus(input logic [1:0] r);
    req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    checkState("reset", GNT_NONE, 1'b0, 1'b0);
    rst_n = 1'b1;

    applyStimulus(2'b10);
    checkState("own1", GNT_1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkState("rstMidGrant", GNT_NONE, 1'b0, 1'b0);
    @(negedge clk);
    req   = 2'b00;
    rst_n = 1'b1;

    applyStimulus(2'b11);
    checkState("contend", GNT_0, 1'b0, 1'b1);
    applyStimulus(2'b10);
    checkState("handoff", GNT_1, 1'b1, 1'b1);
    applyStimulus(2'b00);
    checkState("idleKeepSel", GNT_NONE, 1'b1, 1'b0);
    applyStimulus(2'b11);
    checkState("rotate", GNT_0, 1'b0, 1'b1);
    applyStimulus(2'b00);
    checkState("idle2", GNT_NONE, 1'b0, 1'b0);

    req = 2'b01;
    #1 checkOutput("noCombPath", 32'(grant), 32'(GNT_NONE));
    applyStimulus(2'b01);
    checkState("single0", GNT_0, 1'b0, 1'b1);
    applyStimulus(2'b00);
    checkState("release0", GNT_NONE, 1'b0, 1'b0);

    applyStimulus(2'b01);
    checkState("own0", GNT_0, 1'b0, 1'b1);
    applyStimulus(2'b11);
    checkState("locked", GNT_0, 1'b0, 1'b1);
    applyStimulus(2'b10);
    checkState("backToBack", GNT_1, 1'b1, 1'b1);
    applyStimulus(2'b00);
    checkState("idle3", GNT_NONE, 1'b1, 1'b0);

    applyStimulus(2'b11);
    checkState("holdEntry", GNT_0, 1'b0, 1'b1);
`ifdef MUX_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11);
      checkOutput("holdWindow", 32'(grant), 32'(GNT_0));
    end
    applyStimulus(2'b11);
    checkState("preempt", GNT_1, 1'b1, 1'b1);
    applyStimulus(2'b01);
    checkState("regrant0", GNT_0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(2'b01);
      checkOutput("noCompetitor", 32'(grant), 32'(GNT_0));
    end
    applyStimulus(2'b00);
    checkState("finalIdle", GNT_NONE, 1'b0, 1'b0);
`else
    for (int i = 0; i < 30; i++) begin
      applyStimulus(2'b11);
      checkOutput("noPreempt", 32'(grant), 32'(GNT_0));
    end
    applyStimulus(2'b10);
    checkState("releaseAfterHold", GNT_1, 1'b1, 1'b1);
    applyStimulus(2'b00);
    checkState("finalIdle", GNT_NONE, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
